// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-8 TDM demultiplexer: FSM encoding, slot count
// and slot-index width.
package demux_pkg;

  localparam int SLOTS  = 8;
  localparam int SLOT_W = 3;

  typedef logic [SLOT_W-1:0] slot_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic logic is_last_slot(input slot_t s);
    return s == slot_t'(SLOTS - 1);
  endfunction

endpackage

// File: rtl/demux1x8_tdm_if.sv
// Serial-in / parallel-out bus of the TDM demultiplexer, plus FSM debug state.
// D and SYNC are sampled only on cycles with IN_VALID high; there is no
// backpressure, so every valid beat is consumed on the edge it is presented.
interface demux1x8_tdm_if;
  logic                    D;
  logic                    IN_VALID;
  logic                    SYNC;
  logic [7:0]              Y;
  logic                    Y_VALID;
  demux_pkg::slot_t        S;
  logic                    ERR;
  demux_pkg::state_t       dbg_state;

  modport master (
    output D, IN_VALID, SYNC,
    input  Y, Y_VALID, S, ERR, dbg_state
  );

  modport slave (
    input  D, IN_VALID, SYNC,
    output Y, Y_VALID, S, ERR, dbg_state
  );
endinterface

// File: rtl/tdm_slot_cnt.sv
// Slot index counter: clear to 0, load 1 after a slot-0 capture on resync,
// otherwise increment modulo 8 (natural 3-bit wrap).
module tdm_slot_cnt
  import demux_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  clear,
  input  logic  load1,
  input  logic  inc,
  output slot_t s
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s <= '0;
    end else if (clear) begin
      s <= '0;
    end else if (load1) begin
      s <= slot_t'(1);
    end else if (inc) begin
      s <= s + slot_t'(1);
    end
  end

endmodule

// File: rtl/demux1x8_tdm.sv
// 1-to-8 TDM demultiplexer: IDLE/RUN framing FSM, idle timeout and output registers.
// Define DEMUX1X8_TDM_SHADOW_EN to assemble frames in a shadow register so Y
// only changes together with Y_VALID.
module demux1x8_tdm
  import demux_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           rst,
  demux1x8_tdm_if.slave  bus
);

  localparam logic [7:0] IDLE_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_n;
  logic [7:0] idle_cnt, idle_n;
  slot_t      s, cap_slot;
  logic       cap, frame_done, err_n;
  logic       cnt_clear, cnt_load1, cnt_inc;
  logic [7:0] y;
  logic       y_valid, err;

  tdm_slot_cnt u_slot_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (cnt_clear),
    .load1 (cnt_load1),
    .inc   (cnt_inc),
    .s     (s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idle_cnt <= '0;
    end else begin
      state    <= state_n;
      idle_cnt <= idle_n;
    end
  end

  always_comb begin
    state_n    = state;
    idle_n     = idle_cnt;
    cap        = 1'b0;
    cap_slot   = '0;
    frame_done = 1'b0;
    err_n      = 1'b0;
    cnt_clear  = 1'b0;
    cnt_load1  = 1'b0;
    cnt_inc    = 1'b0;
    unique case (state)
      IDLE: begin
        idle_n = '0;
        if (bus.IN_VALID && bus.SYNC) begin
          cap       = 1'b1;
          cnt_load1 = 1'b1;
          state_n   = RUN;
        end
      end
      RUN: begin
        if (bus.IN_VALID) begin
          idle_n = '0;
          cap    = 1'b1;
          if (bus.SYNC && s != '0) begin
            // Misplaced SYNC: drop the partial frame and restart at slot 0.
            err_n     = 1'b1;
            cnt_load1 = 1'b1;
          end else begin
            cap_slot   = s;
            cnt_inc    = 1'b1;
            frame_done = is_last_slot(s);
          end
        end else if (idle_cnt == IDLE_LAST) begin
          idle_n    = '0;
          state_n   = IDLE;
          cnt_clear = 1'b1;
          err_n     = (s != '0);
        end else begin
          idle_n = idle_cnt + 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef DEMUX1X8_TDM_SHADOW_EN
  logic [SLOTS-1:0] shadow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow  <= '0;
      y       <= '0;
      y_valid <= 1'b0;
      err     <= 1'b0;
    end else begin
      y_valid <= frame_done;
      err     <= err_n;
      if (cap) shadow[cap_slot] <= bus.D;
      if (frame_done) y <= {bus.D, shadow[SLOTS-2:0]};
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y       <= '0;
      y_valid <= 1'b0;
      err     <= 1'b0;
    end else begin
      y_valid <= frame_done;
      err     <= err_n;
      if (cap) y[cap_slot] <= bus.D;
    end
  end
`endif

  assign bus.Y         = y;
  assign bus.Y_VALID   = y_valid;
  assign bus.S         = s;
  assign bus.ERR       = err;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_demux1x8_tdm.sv
// Self-checking bench for demux1x8_tdm: table-driven frames plus hand-written
// resync, timeout, reset and gap sequences; frames checked through exp_q.
module tb_demux1x8_tdm;
  import demux_pkg::*;

  typedef struct {
    logic       v;
    logic       sync;
    logic       d;
    logic [2:0] exp_s;
    logic       exp_yv;
    logic       exp_err;
    logic       push;
    logic [7:0] frame;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  demux1x8_tdm_if bus();

  demux1x8_tdm #(.TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int yv_cnt = 0;
  int err_cnt = 0;
  int yv_cyc[$];
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every Y_VALID pulse pops one expected frame.
  always @(negedge clk) begin
    logic [7:0] e;
    if (!rst) begin
      if (bus.Y_VALID) begin
        yv_cnt++;
        yv_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL y_valid_unexpected: got Y=%0h expected no frame", bus.Y);
        end else begin
          e = exp_q.pop_front();
          check("frame_y", 32'(bus.Y), 32'(e));
        end
      end
      if (bus.ERR) err_cnt++;
    end
  end

  // Driver
  task automatic step(input logic v, input logic sync, input logic d);
    bus.IN_VALID = v;
    bus.SYNC     = sync;
    bus.D        = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_step();
    step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  vec_t tbl[16];

  function automatic vec_t mk(input logic v, sync, d, input logic [2:0] s,
                              input logic yv, input logic push, input logic [7:0] frame);
    vec_t r;
    r.v = v; r.sync = sync; r.d = d; r.exp_s = s;
    r.exp_yv = yv; r.exp_err = 1'b0; r.push = push; r.frame = frame;
    return r;
  endfunction

  initial begin
    logic bad;
    logic [7:0] bits;

    // Back-to-back frames 8'hAA then 8'h55; second SYNC lands at S=0.
    tbl[0]  = mk(1, 1, 0, 3'd1, 0, 0, 8'h00);
    tbl[1]  = mk(1, 0, 1, 3'd2, 0, 0, 8'h00);
    tbl[2]  = mk(1, 0, 0, 3'd3, 0, 0, 8'h00);
    tbl[3]  = mk(1, 0, 1, 3'd4, 0, 0, 8'h00);
    tbl[4]  = mk(1, 0, 0, 3'd5, 0, 0, 8'h00);
    tbl[5]  = mk(1, 0, 1, 3'd6, 0, 0, 8'h00);
    tbl[6]  = mk(1, 0, 0, 3'd7, 0, 0, 8'h00);
    tbl[7]  = mk(1, 0, 1, 3'd0, 1, 1, 8'hAA);
    tbl[8]  = mk(1, 1, 1, 3'd1, 0, 0, 8'h00);
    tbl[9]  = mk(1, 0, 0, 3'd2, 0, 0, 8'h00);
    tbl[10] = mk(1, 0, 1, 3'd3, 0, 0, 8'h00);
    tbl[11] = mk(1, 0, 0, 3'd4, 0, 0, 8'h00);
    tbl[12] = mk(1, 0, 1, 3'd5, 0, 0, 8'h00);
    tbl[13] = mk(1, 0, 0, 3'd6, 0, 0, 8'h00);
    tbl[14] = mk(1, 0, 1, 3'd7, 0, 0, 8'h00);
    tbl[15] = mk(1, 0, 0, 3'd0, 1, 1, 8'h55);

    // Reset state
    rst = 1'b1;
    bus.IN_VALID = 1'b0;
    bus.SYNC     = 1'b0;
    bus.D        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_s", 32'(bus.S), 32'd0);
    check("rst_y", 32'(bus.Y), 32'h00);
    check("rst_yv", 32'(bus.Y_VALID), 32'd0);
    check("rst_err", 32'(bus.ERR), 32'd0);
    check("rst_state", 32'(bus.dbg_state), 32'(IDLE));
    rst = 1'b0;

    // IDLE ignores valid data without SYNC
    step(1, 0, 1);
    step(1, 0, 1);
    check("idle_ignore_s", 32'(bus.S), 32'd0);
    check("idle_ignore_state", 32'(bus.dbg_state), 32'(IDLE));

    // Table: nominal and back-to-back frames
    for (int i = 0; i < 16; i++) begin
      if (tbl[i].push) exp_q.push_back(tbl[i].frame);
      step(tbl[i].v, tbl[i].sync, tbl[i].d);
      check($sformatf("tbl%0d_s", i), 32'(bus.S), 32'(tbl[i].exp_s));
      check($sformatf("tbl%0d_yv", i), 32'(bus.Y_VALID), 32'(tbl[i].exp_yv));
      check($sformatf("tbl%0d_err", i), 32'(bus.ERR), 32'(tbl[i].exp_err));
      check($sformatf("tbl%0d_state", i), 32'(bus.dbg_state), 32'(RUN));
    end
    bus.IN_VALID = 1'b0;
    @(negedge clk);
    #1;
    check("b2b_pulses", 32'(yv_cyc.size()), 32'd2);
    if (yv_cyc.size() == 2) check("b2b_spacing", 32'(yv_cyc[1] - yv_cyc[0]), 32'd8);
    check("b2b_no_err", 32'(err_cnt), 32'd0);

    // Misplaced SYNC at S=3
    step(1, 1, 1);
    step(1, 0, 1);
    step(1, 0, 1);
    check("resync_pre_s", 32'(bus.S), 32'd3);
    step(1, 1, 0);
    check("resync_err", 32'(bus.ERR), 32'd1);
    check("resync_s", 32'(bus.S), 32'd1);
    bits = 8'b1111_1001;  // slots 1..7 = 1,0,0,1,1,1,1 (bit i -> slot i+1)
    bad = 1'b0;
    for (int k = 0; k < 7; k++) begin
      if (k == 6) exp_q.push_back(8'hF2);
      step(1, 0, bits[k]);
      if (k == 0) check("resync_err_once", 32'(bus.ERR), 32'd0);
      if (k < 6 && bus.Y_VALID) bad = 1'b1;
    end
    check("resync_no_early_yv", 32'(bad), 32'd0);
    check("resync_yv", 32'(bus.Y_VALID), 32'd1);
    check("resync_wrap_s", 32'(bus.S), 32'd0);

    // Timeout at S=0: back to IDLE without ERR
    for (int k = 0; k < 15; k++) idle_step();
    check("to0_still_run", 32'(bus.dbg_state), 32'(RUN));
    idle_step();
    check("to0_idle", 32'(bus.dbg_state), 32'(IDLE));
    check("to0_no_err", 32'(bus.ERR), 32'd0);

    // Timeout with a 4-slot partial frame
    step(1, 1, 1);
    step(1, 0, 0);
    step(1, 0, 1);
    step(1, 0, 1);
    check("to_pre_s", 32'(bus.S), 32'd4);
    bad = 1'b0;
    for (int k = 0; k < 15; k++) begin
      idle_step();
      if (bus.ERR || bus.dbg_state != RUN || bus.S != 3'd4) bad = 1'b1;
    end
    check("to_hold_15", 32'(bad), 32'd0);
    idle_step();
    check("to_err", 32'(bus.ERR), 32'd1);
    check("to_state", 32'(bus.dbg_state), 32'(IDLE));
    check("to_s", 32'(bus.S), 32'd0);
`ifdef DEMUX1X8_TDM_SHADOW_EN
    check("to_y_kept", 32'(bus.Y), 32'hF2);
`else
    check("to_y_kept", 32'(bus.Y), 32'hFD);
`endif
    idle_step();
    check("to_err_pulse", 32'(bus.ERR), 32'd0);

    // Reset mid-frame at S=5
    step(1, 1, 1);
    step(1, 0, 0);
    step(1, 0, 1);
    step(1, 0, 0);
    step(1, 0, 1);
    check("mid_pre_s", 32'(bus.S), 32'd5);
    #2;
    rst = 1'b1;
    bus.IN_VALID = 1'b0;
    #1;
    check("mid_rst_s", 32'(bus.S), 32'd0);
    check("mid_rst_y", 32'(bus.Y), 32'h00);
    check("mid_rst_yv", 32'(bus.Y_VALID), 32'd0);
    check("mid_rst_err", 32'(bus.ERR), 32'd0);
    check("mid_rst_state", 32'(bus.dbg_state), 32'(IDLE));
    @(negedge clk);
    rst = 1'b0;
    bits = 8'hF0;
    for (int k = 0; k < 8; k++) begin
      if (k == 7) exp_q.push_back(8'hF0);
      step(1, k == 0, bits[k]);
    end
    check("post_rst_y", 32'(bus.Y), 32'hF0);
    check("post_rst_yv", 32'(bus.Y_VALID), 32'd1);

    // Frame 8'h3C with 3-cycle IN_VALID gaps between slots
    bits = 8'h3C;
    bad = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k == 7) exp_q.push_back(8'h3C);
      step(1, k == 0, bits[k]);
      if (bus.S != 3'((k + 1) % 8) || bus.ERR) bad = 1'b1;
      if (k < 7) begin
        for (int g = 0; g < 3; g++) begin
          idle_step();
          if (bus.S != 3'(k + 1) || bus.ERR || bus.Y_VALID) bad = 1'b1;
        end
      end
    end
    check("gap_slots", 32'(bad), 32'd0);
    check("gap_yv", 32'(bus.Y_VALID), 32'd1);

    // Final report
    idle_step();
    idle_step();
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("total_frames", 32'(yv_cnt), 32'd5);
    check("total_err", 32'(err_cnt), 32'd2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within 100000 time units");
    $fatal(1);
  end

endmodule

// File: doc/demux1x8_tdm.md
DEMUX1X8_TDM -- requirements
Module: demux1x8_tdm

Interface
REQ-001 Parameter TIMEOUT, default 16: consecutive idle cycles in RUN before the frame is abandoned; legal range 2..255.
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 D  input  1  serial data bit for the current slot.
REQ-005 IN_VALID  input  1  D is valid this cycle; the block ignores D when low.
REQ-006 SYNC  input  1  qualified by IN_VALID; marks D as slot 0 (I0) of a frame.
REQ-007 Y  output  8  demultiplexed frame; Y[k] holds the bit received in slot k.
REQ-008 Y_VALID  output  1  one-cycle pulse when a complete 8-slot frame is present on Y.
REQ-009 S  output  3  slot index expected for the next valid bit (mirror of the transmit-side select S2..S0).
REQ-010 ERR  output  1  one-cycle pulse on a framing error or timeout with a partial frame.

Function
REQ-011 The FSM SHALL have exactly two states: IDLE and RUN.
REQ-012 In IDLE, IN_VALID=1 with SYNC=0 SHALL be ignored, with S held at 0.
REQ-013 In IDLE, IN_VALID=1 with SYNC=1 SHALL capture D as slot 0, set S=1 and enter RUN.
REQ-014 In RUN, IN_VALID=1 with SYNC=0 SHALL capture D into slot S and increment S modulo 8.
REQ-015 In RUN, IN_VALID=1 with SYNC=1 and S=0 SHALL be accepted as a normal slot-0 capture.
REQ-016 In RUN, IN_VALID=1 with SYNC=1 and S!=0 SHALL pulse ERR, discard the partial frame, capture D as slot 0 and set S=1 (resync).
REQ-017 The edge that captures slot 7 SHALL assert Y_VALID for exactly the following cycle, with Y holding all 8 bits of that frame; S wraps to 0 and the FSM stays in RUN.
REQ-018 The latency from the slot-7 capture edge to Y/Y_VALID SHALL be 0 cycles (registered outputs updated on that same edge).
REQ-019 In RUN, an idle counter SHALL count consecutive cycles with IN_VALID=0 and clear on any IN_VALID=1.
REQ-020 When the idle counter reaches TIMEOUT, the block SHALL return to IDLE with S=0, pulse ERR only if S!=0, and leave Y unchanged.
REQ-021 Bits of a discarded partial frame SHALL never produce a Y_VALID pulse.

Reset
REQ-022 Asserting rst SHALL immediately force IDLE, S=0, Y=8'h00, Y_VALID=0, ERR=0 and idle counter=0, including mid-frame.
REQ-023 The first rising clk edge after rst deasserts SHALL be treated as a normal IDLE cycle.

Configuration
REQ-024 Macro DEMUX1X8_TDM_SHADOW_EN, when defined, SHALL collect bits in an internal shadow register and copy all 8 bits to Y only on the slot-7 capture edge, so Y changes only alongside Y_VALID.
REQ-025 When DEMUX1X8_TDM_SHADOW_EN is undefined, each captured bit SHALL be written directly to Y[S]; Y is then transparent mid-frame, while Y_VALID timing is unchanged.

Structure
REQ-026 A shared package demux_pkg SHALL hold the state encoding (IDLE=0, RUN=1), SLOTS=8, and the slot-index width 3.
REQ-027 The slot counter, including its modulo-8 wrap, resync load and clear, SHALL be a sub-module named tdm_slot_cnt; the FSM, idle counter and output registers stay in demux1x8_tdm.

Verification
REQ-028 The bench SHALL cover a nominal frame: SYNC+D=0 for slot 0, then D=1,0,1,0,1,0,1 on 7 consecutive valid cycles -> Y=8'hAA with a 1-cycle Y_VALID; S sequence 1..7 then 0.
REQ-029 The bench SHALL cover back-to-back frames: 8'hAA then 8'h55 with no gap -> two Y_VALID pulses exactly 8 cycles apart and ERR never asserted.
REQ-030 The bench SHALL cover a misplaced SYNC: SYNC asserted at S=3 -> ERR pulses once, S=1 on the next cycle, and no Y_VALID until 7 further valid bits arrive.
REQ-031 The bench SHALL cover a timeout: with TIMEOUT=16, stop IN_VALID after 4 slots -> ERR pulses on the 16th idle cycle, the FSM is in IDLE with S=0, and Y keeps its previous frame (shadow build).
REQ-032 The bench SHALL cover reset mid-frame: assert rst at S=5 -> all outputs zero asynchronously; a new SYNC frame 8'hF0 after release -> Y=8'hF0 with Y_VALID.
REQ-033 The bench SHALL cover IN_VALID gaps: insert 3-cycle gaps between slots (less than TIMEOUT) -> frame still completes correctly and ERR is never asserted.
